// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the base value of the port-ID header byte.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_BODY   = 2'd2
    } arb_state_t;

    localparam logic [7:0] HEADER_BASE = 8'h30;

    function automatic logic [7:0] header_byte(input logic [7:0] port_idx);
        return HEADER_BASE + port_idx;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: one-hot of the first set request at or
// after ptr, wrapping modulo N; all zero when nothing is requested.
module rr_priority_select #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;
    logic          found;
    int            sum;

    always_comb begin
        onehot = '0;
        found  = 1'b0;
        idx    = '0;
        sum    = 0;
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N) sum = sum - N;
            idx = PW'(sum);
            if (!found && req[idx]) begin
                onehot[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serialises whole messages from several requesters
// onto one UART transmitter, optionally prefixing each with a port-ID header.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int HEADER_EN = 1,
    parameter int TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PORTS*8-1:0] req_data,
    input  logic [NUM_PORTS-1:0]   req_ready,
    input  logic [NUM_PORTS-1:0]   req_last,
    output logic [NUM_PORTS-1:0]   req_accepted,
    output logic [7:0]             tx_data,
    output logic                   tx_data_ready,
    input  logic                   tx_data_accepted,
    output logic [NUM_PORTS-1:0]   grant,
    output logic [15:0]            timeout_count
);
    localparam int          PW          = $clog2(NUM_PORTS);
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 1);

    arb_state_t           state_q, state_d;
    logic [NUM_PORTS-1:0] sel_onehot;
    logic [PW-1:0]        sel_idx, gidx_q, rr_ptr_q, next_ptr;
    logic [7:0]           hdr_q, g_data;
    logic [15:0]          stall_q;
    logic                 g_ready, g_last, body_accept, timeout_hit, msg_done;

    rr_priority_select #(.N(NUM_PORTS)) u_sel (
        .req    (req_ready),
        .ptr    (rr_ptr_q),
        .onehot (sel_onehot)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_onehot[i]) sel_idx = PW'(i);
        end
    end

    assign g_ready     = req_ready[gidx_q];
    assign g_last      = req_last[gidx_q];
    assign g_data      = req_data[int'(gidx_q)*8 +: 8];
    assign body_accept = (state_q == ST_BODY) && g_ready && tx_data_accepted;
    // A timeout wins over a coincident accept: both end the message on this edge.
    assign timeout_hit = (state_q == ST_BODY) && (stall_q == STALL_LIMIT);
    assign msg_done    = timeout_hit || (body_accept && g_last);
    assign next_ptr    = (gidx_q == PW'(NUM_PORTS - 1)) ? '0 : gidx_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        tx_data       = '0;
        tx_data_ready = 1'b0;
        req_accepted  = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req_ready) state_d = (HEADER_EN != 0) ? ST_HEADER : ST_BODY;
            end
            ST_HEADER: begin
                tx_data       = hdr_q;
                tx_data_ready = 1'b1;
                if (tx_data_accepted) state_d = ST_BODY;
            end
            ST_BODY: begin
                tx_data       = g_data;
                tx_data_ready = g_ready;
                req_accepted  = body_accept ? grant : '0;
                if (msg_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant         <= '0;
            gidx_q        <= '0;
            rr_ptr_q      <= '0;
            hdr_q         <= '0;
            stall_q       <= '0;
            timeout_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && |req_ready) begin
                grant  <= sel_onehot;
                gidx_q <= sel_idx;
                hdr_q  <= header_byte(8'(sel_idx));
            end else if (msg_done) begin
                grant    <= '0;
                rr_ptr_q <= next_ptr;
            end
            if (state_q != ST_BODY || msg_done || body_accept) begin
                stall_q <= '0;
            end else if (!g_ready) begin
                stall_q <= stall_q + 16'd1;
            end
            if (timeout_hit && timeout_count != 16'hFFFF) begin
                timeout_count <= timeout_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a requester model feeds per-port byte
// buffers while monitors compare each UART transfer against a scoreboard queue.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] grant;
        logic       hdr;
    } exp_t;

    localparam logic [7:0] HDR = 8'h30;

    logic        clk, rst;
    logic [31:0] req_data;
    logic [3:0]  req_ready, req_last, req_accepted, grant;
    logic [7:0]  tx_data;
    logic        tx_data_ready, tx_data_accepted;
    logic [15:0] timeout_count;

    logic [31:0] nh_req_data;
    logic [3:0]  nh_req_ready, nh_req_last, nh_req_accepted, nh_grant;
    logic [7:0]  nh_tx_data;
    logic        nh_tx_data_ready, nh_tx_data_accepted;
    logic [15:0] nh_timeout_count;

    int         n_checks, n_fail;
    exp_t       exp_q[$];
    exp_t       nh_q[$];
    logic [8:0] pbuf [4][32];
    int         phead[4];
    int         ptail[4];
    logic [3:0] acc_seen;
    logic       uart_en, throttle, drop_all;
    int         cyc;

    uart_tx_arbiter #(.NUM_PORTS(4), .HEADER_EN(1), .TIMEOUT(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .req_last         (req_last),
        .req_accepted     (req_accepted),
        .tx_data          (tx_data),
        .tx_data_ready    (tx_data_ready),
        .tx_data_accepted (tx_data_accepted),
        .grant            (grant),
        .timeout_count    (timeout_count)
    );

    uart_tx_arbiter #(.NUM_PORTS(4), .HEADER_EN(0), .TIMEOUT(16)) dut_nh (
        .clk              (clk),
        .rst              (rst),
        .req_data         (nh_req_data),
        .req_ready        (nh_req_ready),
        .req_last         (nh_req_last),
        .req_accepted     (nh_req_accepted),
        .tx_data          (nh_tx_data),
        .tx_data_ready    (nh_tx_data_ready),
        .tx_data_accepted (nh_tx_data_accepted),
        .grant            (nh_grant),
        .timeout_count    (nh_timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester model: each port presents the head of its buffer.
    always_comb begin
        req_ready = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < 4; i++) begin
            if (phead[i] != ptail[i]) begin
                req_ready[i]        = 1'b1;
                req_data[i*8 +: 8]  = pbuf[i][phead[i]][7:0];
                req_last[i]         = pbuf[i][phead[i]][8];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [7:0] data, input logic last);
        pbuf[port][ptail[port]] = {last, data};
        ptail[port] = ptail[port] + 1;
    endtask

    task automatic push_exp(input logic [7:0] data, input int port, input logic hdr);
        exp_t e;
        e.data  = data;
        e.grant = 4'(1 << port);
        e.hdr   = hdr;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        checkOutput(name, exp_q.size(), 0);
        checkOutput({name, "_grant_idle"}, grant, 4'b0000);
        checkOutput({name, "_ready_idle"}, tx_data_ready, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_tx_data"}, tx_data, 8'h00);
        checkOutput({tag, "_tx_data_ready"}, tx_data_ready, 1'b0);
        checkOutput({tag, "_grant"}, grant, 4'b0000);
        checkOutput({tag, "_req_accepted"}, req_accepted, 4'b0000);
        checkOutput({tag, "_timeout_count"}, timeout_count, 16'd0);
    endtask

    // Main monitor: every UART transfer is matched against the scoreboard head.
    initial begin
        acc_seen = '0;
        forever begin
            @(negedge clk);
            acc_seen = rst ? 4'b0000 : req_accepted;
            if (!rst && tx_data_ready && tx_data_accepted) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_tx: actual %0h required no transfer", tx_data);
                end else begin
                    checkOutput("tx_data", tx_data, exp_q[0].data);
                    checkOutput("tx_grant", grant, exp_q[0].grant);
                    checkOutput("req_accepted", req_accepted, exp_q[0].hdr ? 4'b0000 : exp_q[0].grant);
                    void'(exp_q.pop_front());
                end
            end else if (!rst) begin
                checkOutput("req_accepted_no_xfer", req_accepted, 4'b0000);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && nh_tx_data_ready && nh_tx_data_accepted) begin
                if (nh_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL nh_unexpected_tx: actual %0h required no transfer", nh_tx_data);
                end else begin
                    checkOutput("nh_tx_data", nh_tx_data, nh_q[0].data);
                    checkOutput("nh_grant", nh_grant, nh_q[0].grant);
                    checkOutput("nh_req_accepted", nh_req_accepted, nh_q[0].grant);
                    void'(nh_q.pop_front());
                end
            end
        end
    end

    // Driver: retire accepted bytes and pace the UART accept pulse.
    initial begin
        tx_data_accepted = 1'b0;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (drop_all) phead[i] = ptail[i];
                else if (acc_seen[i] && phead[i] != ptail[i]) phead[i] = phead[i] + 1;
            end
            cyc++;
            tx_data_accepted = uart_en && (!throttle || cyc[0]);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual time limit reached required test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        uart_en  = 1'b1;
        throttle = 1'b0;
        drop_all = 1'b0;
        nh_req_data = '0;
        nh_req_ready = '0;
        nh_req_last = '0;
        nh_tx_data_accepted = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] all four ports, two single-byte messages each");
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i, 8'(8'h60 + i), 1'b1);
            applyStimulus(i, 8'(8'h70 + i), 1'b1);
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                push_exp(8'(HDR + i), i, 1'b1);
                push_exp(8'((r == 0 ? 8'h60 : 8'h70) + i), i, 1'b0);
            end
        end
        wait_drain("drain_rr");

        $display("[TB] port 0 three-byte message");
        @(posedge clk);
        #2;
        applyStimulus(0, 8'h41, 1'b0);
        applyStimulus(0, 8'h42, 1'b0);
        applyStimulus(0, 8'h43, 1'b1);
        push_exp(8'h30, 0, 1'b1);
        push_exp(8'h41, 0, 1'b0);
        push_exp(8'h42, 0, 1'b0);
        push_exp(8'h43, 0, 1'b0);
        wait_drain("drain_p0");

        $display("[TB] ports 1 and 2 together, throttled UART");
        throttle = 1'b1;
        @(posedge clk);
        #2;
        applyStimulus(1, 8'hA1, 1'b0);
        applyStimulus(1, 8'hA2, 1'b1);
        applyStimulus(2, 8'hB1, 1'b0);
        applyStimulus(2, 8'hB2, 1'b1);
        push_exp(8'h31, 1, 1'b1);
        push_exp(8'hA1, 1, 1'b0);
        push_exp(8'hA2, 1, 1'b0);
        push_exp(8'h32, 2, 1'b1);
        push_exp(8'hB1, 2, 1'b0);
        push_exp(8'hB2, 2, 1'b0);
        wait_drain("drain_p12");
        throttle = 1'b0;

        $display("[TB] port 3 stalls mid-message while port 0 waits");
        @(posedge clk);
        #2;
        applyStimulus(3, 8'h99, 1'b0);
        applyStimulus(0, 8'h11, 1'b1);
        push_exp(8'h33, 3, 1'b1);
        push_exp(8'h99, 3, 1'b0);
        push_exp(8'h30, 0, 1'b1);
        push_exp(8'h11, 0, 1'b0);
        wait_drain("drain_timeout");
        checkOutput("timeout_count", timeout_count, 16'd1);

        $display("[TB] reset during a port 2 message");
        @(posedge clk);
        #2;
        applyStimulus(2, 8'hC1, 1'b0);
        applyStimulus(2, 8'hC2, 1'b0);
        applyStimulus(2, 8'hC3, 1'b1);
        push_exp(8'h32, 2, 1'b1);
        push_exp(8'hC1, 2, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("pre_reset_grant", grant, 4'b0100);
        checkOutput("pre_reset_ready", tx_data_ready, 1'b1);
        checkOutput("pre_reset_data", tx_data, 8'hC2);
        #1;
        rst = 1'b1;
        drop_all = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        checkOutput("trunc_drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        drop_all = 1'b0;
        @(posedge clk);
        #2;
        applyStimulus(2, 8'hD1, 1'b1);
        applyStimulus(0, 8'hE1, 1'b1);
        push_exp(8'h30, 0, 1'b1);
        push_exp(8'hE1, 0, 1'b0);
        push_exp(8'h32, 2, 1'b1);
        push_exp(8'hD1, 2, 1'b0);
        wait_drain("drain_after_reset");

        $display("[TB] headerless instance, port 1 single byte");
        nh_tx_data_accepted = 1'b1;
        @(posedge clk);
        #2;
        nh_req_data  = 32'h0000_5500;
        nh_req_ready = 4'b0010;
        nh_req_last  = 4'b0010;
        begin
            exp_t e;
            e.data  = 8'h55;
            e.grant = 4'b0010;
            e.hdr   = 1'b0;
            nh_q.push_back(e);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (nh_req_accepted[1]) break;
        end
        @(posedge clk);
        #2;
        nh_req_ready = 4'b0000;
        nh_req_last  = 4'b0000;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("nh_drain", nh_q.size(), 0);
        checkOutput("nh_grant_idle", nh_grant, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter HEADER_EN, default 1: when 1, each message is prefixed with a one-byte port-ID header.
REQ-003 Parameter TIMEOUT, default 1024: stall cycles before a locked grant is revoked, legal range 2..65535.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_data  in  NUM_PORTS*8  byte from each port; port i occupies bits [8i+7:8i].
REQ-008 req_ready  in  NUM_PORTS  port i holds a valid byte.
REQ-009 req_last  in  NUM_PORTS  current byte of port i is the final byte of its message.
REQ-010 req_accepted  out  NUM_PORTS  one-cycle pulse; byte of port i consumed.
REQ-011 tx_data  out  8  byte presented to the UART transmitter.
REQ-012 tx_data_ready  out  1  tx_data is valid.
REQ-013 tx_data_accepted  in  1  one-cycle pulse from the UART; byte consumed.
REQ-014 grant  out  NUM_PORTS  one-hot owner of the UART, or all zero when idle.
REQ-015 timeout_count  out  16  saturating count of revoked grants.

Function
REQ-016 The block SHALL implement three states: IDLE, HEADER and BODY.
REQ-017 IDLE: tx_data_ready=0; if any req_ready bit is set, the block SHALL grant the first set port at or after rr_ptr (modulo NUM_PORTS), then go to HEADER (HEADER_EN=1) or BODY (HEADER_EN=0).
REQ-018 Grant latency SHALL be exactly one cycle: a request sampled in IDLE at edge t drives grant and tx_data_ready from t+1.
REQ-019 HEADER: tx_data SHALL be held at 8'h30 + granted index and tx_data_ready=1; on tx_data_accepted, go to BODY.
REQ-020 BODY: tx_data SHALL equal req_data of the granted port and tx_data_ready SHALL equal req_ready of the granted port, both combinational pass-through.
REQ-021 BODY: req_accepted[grant] SHALL equal tx_data_accepted in the same cycle; req_accepted SHALL never assert for a non-granted port or outside BODY.
REQ-022 BODY: an accept with req_last[grant]=1 SHALL return the block to IDLE and set rr_ptr = grant+1 (wrapping at NUM_PORTS).
REQ-023 Bytes from different ports SHALL never interleave within a message; a new grant occurs only from IDLE, so one IDLE bubble follows every message.
REQ-024 tx_data_accepted while tx_data_ready=0 SHALL be ignored.
REQ-025 Stall counter: in BODY, increment each cycle req_ready[grant]=0; clear on accept and on state entry.
REQ-026 When the stall counter reaches TIMEOUT-1, the block SHALL go to IDLE, advance rr_ptr past the granted port, and increment timeout_count, saturating at 16'hFFFF.
REQ-027 A timeout SHALL take effect on the same edge as any coincident accept.
REQ-028 The requester SHALL hold req_data and req_last stable until accepted; the arbiter does not buffer data.

Reset
REQ-029 On rst: state=IDLE, rr_ptr=0, stall counter=0, tx_data=0, tx_data_ready=0, grant=0, req_accepted=0, timeout_count=0.
REQ-030 Reset SHALL take effect immediately and independently of clk.
REQ-031 Reset mid-message SHALL truncate the message with no further bytes emitted; after release, port 0 has first priority.

Structure
REQ-032 State encoding constants and HEADER_BASE (8'h30) SHALL live in shared package uart_tx_arbiter_pkg.
REQ-033 Round-robin selection SHALL be a combinational sub-module, rr_priority_select, with inputs req and ptr and output onehot.
REQ-034 All outputs except req_accepted, tx_data and tx_data_ready (in BODY) SHALL be registered.

Verification
REQ-035 Port 0 sends 0x41, 0x42, 0x43 (last) -> UART sees 0x30, 0x41, 0x42, 0x43; grant 0001 then 0000.
REQ-036 Ports 1 and 2 request on the same cycle, 2 bytes each -> 0x31, p1b0, p1b1, then 0x32, p2b0, p2b1; no interleave.
REQ-037 All four ports continuously send 1-byte messages -> header order 0x30, 0x31, 0x32, 0x33, 0x30.
REQ-038 TIMEOUT=16; port 3 sends a non-last byte then drops req_ready while port 0 waits -> after 16 stall cycles grant=0001 and timeout_count=1.
REQ-039 Assert rst during BODY -> all outputs 0 before the next edge; after release, ports 2 and 0 both requesting -> port 0 granted.
REQ-040 HEADER_EN=0, port 1 sends 0x55 (last) -> UART sees only 0x55.
